// File: rtl/avalon_frame_buffer_slave.sv
// Avalon-MM frame-buffer slave: on-chip word array behind programmable wait states,
// fixed-latency pipelined reads and a saturating error counter. Optional: LFSR_WAIT_EN.
module avalon_frame_buffer_slave #(
    parameter int ADDRESSWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR = 'h08000000,
    parameter int WAIT_STATES = 1,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDRESSWIDTH-1:0] slave_address,
    input  logic [DATAWIDTH-1:0]    slave_writedata,
    input  logic                    slave_write,
    input  logic                    slave_read,
    output logic                    slave_waitrequest,
    output logic [DATAWIDTH-1:0]    slave_readdata,
    output logic                    slave_readdatavalid,
    output logic [15:0]             err_count,
    output logic                    busy
);

    localparam int WORDS = 2 ** DEPTH_LOG2;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [DATAWIDTH-1:0] BAD_DATA = DATAWIDTH'(32'hBAD0BAD0);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] lim_idle, lim_wait;
    logic req, accept;

    assign req = slave_read | slave_write;

`ifdef LFSR_WAIT_EN
    logic [7:0] lfsr;
    logic [3:0] lim_q;

    assign lim_idle = 4'({1'b0, lfsr[3:0]} % 5'(WAIT_STATES + 1));
    assign lim_wait = lim_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr  <= 8'hA5;
            lim_q <= 4'd0;
        end else begin
            if (accept)
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (state == IDLE && req)
                lim_q <= lim_idle;
        end
    end
`else
    assign lim_idle = WS;
    assign lim_wait = WS;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (lim_idle == 4'd0) begin
                        accept = 1'b1;
                    end else begin
                        cnt_nxt   = 4'd1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt < lim_wait) begin
                    cnt_nxt = cnt + 4'd1;
                end else begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    assign slave_waitrequest = req & ~accept;

    logic [ADDRESSWIDTH-1:0] off;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    in_range, misaligned;
    logic                    wr_acc, rd_acc, err_hit;
    logic [DATAWIDTH-1:0]    rd_data;
    logic [DATAWIDTH-1:0]    mem [WORDS];

    assign off        = slave_address - BASE_ADDR;
    assign idx        = off[DEPTH_LOG2+1:2];
    assign misaligned = |off[1:0];
    assign in_range   = (slave_address >= BASE_ADDR)
                     && (off[ADDRESSWIDTH-1:DEPTH_LOG2+2] == '0);

    // A simultaneous read+write is serviced as a write only.
    assign wr_acc  = accept & slave_write;
    assign rd_acc  = accept & slave_read & ~slave_write;
    assign err_hit = accept & (misaligned | ~in_range
                            | (slave_read & slave_write));
    assign rd_data = in_range ? mem[idx] : BAD_DATA;

    always_ff @(posedge clk) begin
        if (reset_n && wr_acc && in_range)
            mem[idx] <= slave_writedata;
    end

    logic [READ_LATENCY-1:0] pv;
    logic [DATAWIDTH-1:0]    pd [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pv                  <= '0;
            slave_readdatavalid <= 1'b0;
            slave_readdata      <= '0;
            err_count           <= 16'd0;
            for (int i = 0; i < READ_LATENCY; i++)
                pd[i] <= '0;
        end else begin
            pv[0] <= rd_acc;
            pd[0] <= rd_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            slave_readdatavalid <= pv[READ_LATENCY-1];
            if (pv[READ_LATENCY-1])
                slave_readdata <= pd[READ_LATENCY-1];
            if (err_hit && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

    assign busy = |pv;

endmodule

// File: tb/tb_avalon_frame_buffer_slave.sv
// Bench for avalon_frame_buffer_slave: directed table, wait/reset corner
// sequences and random traffic against a word-array reference model.
module tb_avalon_frame_buffer_slave;

    localparam logic [31:0] BASE = 32'h08000000;
    localparam int WS = 1;
    localparam int L = 2;
    localparam logic [31:0] BAD = 32'hBAD0BAD0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] slave_address;
    logic [31:0] slave_writedata;
    logic        slave_write;
    logic        slave_read;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic [15:0] err_count;
    logic        busy;

    avalon_frame_buffer_slave #(
        .ADDRESSWIDTH(32),
        .DATAWIDTH(32),
        .DEPTH_LOG2(8),
        .BASE_ADDR(BASE),
        .WAIT_STATES(WS),
        .READ_LATENCY(L)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .slave_address(slave_address),
        .slave_writedata(slave_writedata),
        .slave_write(slave_write),
        .slave_read(slave_read),
        .slave_waitrequest(slave_waitrequest),
        .slave_readdata(slave_readdata),
        .slave_readdatavalid(slave_readdatavalid),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        int          c;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          rd;
        bit          wr;
        logic [31:0] xdata;
        int          xerr;
    } vec_t;

    rsp_t        rq[$];
    logic [31:0] mmem [256];
    int          m_err;
    logic [7:0]  m_lf;
    logic [31:0] last_rd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Response monitor: order, data, exact latency and hold behaviour.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset_n) begin
            last_rd = 32'h0;
        end else if (slave_readdatavalid) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdv actual=%h required=none",
                         slave_readdata);
                last_rd = slave_readdata;
            end else begin
                e = rq.pop_front();
                chk("rdata", slave_readdata, e.d);
                chk("rdv_cycle", cyc, e.c);
                last_rd = e.d;
            end
        end else begin
            chk("rdata_hold", slave_readdata, last_rd);
        end
    end

    function automatic void decode(input logic [31:0] a, output bit inr,
                                   output int idx, output bit mis);
        longint ua, ub;
        ua = a;
        ub = BASE;
        inr = (ua >= ub) && ((ua - ub) < 1024);
        idx = inr ? int'((ua - ub) / 4) : 0;
        mis = (ua % 4) != 0;
    endfunction

    task automatic cmd(input logic [31:0] a, input logic [31:0] wd,
                       input bit rd, input bit wr,
                       input bit xuse, input logic [31:0] xd);
        int w, idx, exp_w;
        bit inr, mis, e;
        logic [31:0] d;
`ifdef LFSR_WAIT_EN
        exp_w = int'(m_lf[3:0]) % (WS + 1);
`else
        exp_w = WS;
`endif
        @(negedge clk);
        slave_address = a;
        slave_writedata = wd;
        slave_read = rd;
        slave_write = wr;
        w = 0;
        #1;
        while (slave_waitrequest !== 1'b0 && w <= 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w > 40) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d required=%0d", w, exp_w);
            slave_read = 1'b0;
            slave_write = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        slave_read = 1'b0;
        slave_write = 1'b0;
        m_lf = {m_lf[6:0], m_lf[7] ^ m_lf[5] ^ m_lf[4] ^ m_lf[3]};
        decode(a, inr, idx, mis);
        e = mis || !inr || (rd && wr);
        if (wr) begin
            if (inr) mmem[idx] = wd;
        end else if (rd) begin
            d = inr ? mmem[idx] : BAD;
            if (xuse) d = xd;
            rq.push_back('{d, cyc + L});
            chk("busy_inflight", 32'(busy), 32'h1);
        end
        if (e && m_err < 65535) m_err++;
        chk("wait_cycles", w, exp_w);
        chk("err_count", 32'(err_count), m_err);
    endtask

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int op;
        reset_n = 1'b0;
        slave_address = '0;
        slave_writedata = '0;
        slave_read = 1'b0;
        slave_write = 1'b0;
        m_err = 0;
        m_lf = 8'hA5;

        tbl.push_back('{32'h08000004, 32'h00FFFF00, 0, 1, 32'h0, 0});
        tbl.push_back('{32'h08000004, 32'h0, 1, 0, 32'h00FFFF00, 0});
        tbl.push_back('{32'h08000000, 32'h1, 0, 1, 32'h0, 0});
        tbl.push_back('{32'h08000004, 32'h2, 0, 1, 32'h0, 0});
        tbl.push_back('{32'h08000008, 32'h3, 0, 1, 32'h0, 0});
        tbl.push_back('{32'h08000000, 32'h0, 1, 0, 32'h1, 0});
        tbl.push_back('{32'h08000004, 32'h0, 1, 0, 32'h2, 0});
        tbl.push_back('{32'h08000008, 32'h0, 1, 0, 32'h3, 0});
        tbl.push_back('{32'h080003FC, 32'hCAFEF00D, 0, 1, 32'h0, 0});
        tbl.push_back('{32'h08000400, 32'h0, 1, 0, 32'hBAD0BAD0, 1});
        tbl.push_back('{32'h07FFFFFC, 32'hDEADBEEF, 0, 1, 32'h0, 2});
        tbl.push_back('{32'h080003FC, 32'h0, 1, 0, 32'hCAFEF00D, 2});
        tbl.push_back('{32'h08000008, 32'h12345678, 1, 1, 32'h0, 3});
        tbl.push_back('{32'h08000008, 32'h0, 1, 0, 32'h12345678, 3});
        tbl.push_back('{32'h08000011, 32'h55AA55AA, 0, 1, 32'h0, 4});
        tbl.push_back('{32'h08000010, 32'h0, 1, 0, 32'h55AA55AA, 4});
        tbl.push_back('{32'h08000002, 32'h0, 1, 0, 32'h1, 5});

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_rdv", 32'(slave_readdatavalid), 32'h0);
        chk("rst_rdata", slave_readdata, 32'h0);
        chk("rst_err", 32'(err_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_waitreq", 32'(slave_waitrequest), 32'h0);

`ifndef LFSR_WAIT_EN
        @(negedge clk);
        slave_address = BASE;
        slave_read = 1'b1;
        #1 chk("drop_stall", 32'(slave_waitrequest), 32'h1);
        @(posedge clk);
        #1 slave_read = 1'b0;
        #1 chk("drop_noreq", 32'(slave_waitrequest), 32'h0);
        @(negedge clk);
        chk("drop_err", 32'(err_count), 32'h0);
        cmd(BASE + 32'd12, 32'h0, 0, 1, 0, 32'h0);
`endif

        foreach (tbl[i]) begin
            cmd(tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].wr,
                1, tbl[i].xdata);
            chk($sformatf("tbl%0d_err", i), 32'(err_count), tbl[i].xerr);
        end
        repeat (L + 3) @(negedge clk);
        chk("busy_idle", 32'(busy), 32'h0);
        chk("rsp_left", rq.size(), 32'h0);

        for (int i = 0; i < 256; i++)
            cmd(BASE + 32'(4 * i), $urandom, 0, 1, 0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = BASE + 32'(4 * $urandom_range(0, 255));
                6: a = BASE + 32'(4 * $urandom_range(0, 255))
                       + 32'($urandom_range(1, 3));
                7: a = BASE - 32'(4 * $urandom_range(1, 64));
                8: a = BASE + 32'h400 + 32'(4 * $urandom_range(0, 1000));
                default: a = $urandom;
            endcase
            op = $urandom_range(0, 9);
            cmd(a, $urandom, op < 5 || op == 9, op >= 5, 0, 32'h0);
        end
        repeat (L + 3) @(negedge clk);
        chk("rnd_rsp_left", rq.size(), 32'h0);

        cmd(BASE, 32'h0, 1, 0, 0, 32'h0);
        reset_n = 1'b0;
        rq.delete();
        m_err = 0;
        m_lf = 8'hA5;
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_err", 32'(err_count), 32'h0);
        chk("midrst_rdv", 32'(slave_readdatavalid), 32'h0);
        repeat (L + 3) @(negedge clk);
        cmd(BASE + 32'd20, 32'h0, 1, 0, 0, 32'h0);
        repeat (L + 3) @(negedge clk);
        chk("final_rsp_left", rq.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_frame_buffer_slave.md
Name: avalon_frame_buffer_slave

Overview:
- Avalon-MM slave responder for the frame-buffer master path; answers master_address/read/write with waitrequest and pipelined, fixed-latency readdatavalid.
- Backed by an on-chip word array mapped at BASE_ADDR.
- Programmable wait states and counted protocol errors let the custom master be exercised standalone, without the SDRAM controller.

Parameters:
- ADDRESSWIDTH, 32, byte-address width.
- DATAWIDTH, 32, data width.
- DEPTH_LOG2, 8, log2 of the word count (256 words).
- BASE_ADDR, 32'h08000000, byte address of word 0.
- WAIT_STATES, 1, waitrequest cycles inserted before each accept (0..15).
- READ_LATENCY, 2, cycles from accept edge to readdatavalid (1..8).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- slave_address  in  ADDRESSWIDTH  byte address
- slave_writedata  in  DATAWIDTH  write data
- slave_write  in  1  write request
- slave_read  in  1  read request
- slave_waitrequest  out  1  stall; command accepted on the edge where request=1 and waitrequest=0
- slave_readdata  out  DATAWIDTH  read response data
- slave_readdatavalid  out  1  one-cycle pulse per accepted read
- err_count  out  16  saturating protocol/range error counter
- busy  out  1  high while any read response is in flight

Behaviour:
- Reset (reset_n=0 at clk edge):
  - state=IDLE, wait counter=0, read pipeline cleared.
  - readdata=0, readdatavalid=0, err_count=0, busy=0.
  - Memory contents are not reset.
- waitrequest is combinational from state and request:
  - 0 when no request is present.
  - 0 on the accept cycle.
  - Otherwise 1.
- FSM states: IDLE, WAIT.
- IDLE:
  - Request present and WAIT_STATES=0: accept this cycle.
  - Request present and WAIT_STATES>0: waitrequest=1, cnt<=1, go to WAIT.
- WAIT:
  - cnt<WAIT_STATES: waitrequest=1, cnt++.
  - cnt==WAIT_STATES: waitrequest=0, accept, go to IDLE.
  - Request dropped during WAIT: return to IDLE, no access, no error.
- Only one access is accepted per accept cycle. Back-to-back commands each pay the full WAIT_STATES.
- Decode:
  - off = address - BASE_ADDR (ADDRESSWIDTH-bit subtract).
  - In range iff address >= BASE_ADDR and off[ADDRESSWIDTH-1:2] < 2**DEPTH_LOG2.
  - index = off[DEPTH_LOG2+1:2].
  - off[1:0] != 0: access proceeds with the low bits ignored, and err_count increments.
- Write accept: in range updates mem[index] at the accept edge. Out of range is dropped and err_count increments.
- Read accept:
  - Pushes {1, data} into a READ_LATENCY-deep shift pipeline.
  - data = mem[index], or 32'hBAD0BAD0 if out of range (err_count increments).
  - readdatavalid/readdata appear exactly READ_LATENCY cycles after the accept edge, held for one cycle. Responses are strictly in order.
  - readdata holds its last value when readdatavalid=0.
- Read-after-write to the same word on consecutive accepts returns the new data.
- read and write both high: treated as a write only; err_count increments once, at accept.
- Multiple error conditions on one access increment err_count by 1 only. err_count saturates at 16'hFFFF.
- busy = OR of the pipeline valid bits.
- Reset mid-operation clears in-flight responses; no readdatavalid is produced after reset.

Optional Feature:
- Macro LFSR_WAIT_EN.
- Defined:
  - Per-command wait count = lfsr[3:0] mod (WAIT_STATES+1), sampled when the request first appears in IDLE.
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5 on reset, advances one step per accept.
- Undefined: fixed WAIT_STATES for every command; no LFSR logic present.

Test Plan:
- Reset, WAIT_STATES=1, write 32'h00FFFF00 to 0x08000004 -> waitrequest 1 for one cycle then 0; mem[1]=32'h00FFFF00; err_count=0.
- Read 0x08000004 accepted at edge T -> readdatavalid=1 with readdata=32'h00FFFF00 at edge T+2 only.
- Three back-to-back reads of 0x08000000/04/08 (values 1,2,3) -> three single-cycle valid pulses, in order 1,2,3; busy high from first accept until after the last pulse.
- Read 0x08000400 (out of range) -> readdata 32'hBAD0BAD0 with valid; err_count=1. Write to 0x07FFFFFC -> memory unchanged; err_count=2.
- read and write asserted together at 0x08000008 with data 32'h12345678 -> mem[2]=32'h12345678, no readdatavalid, err_count+1.
- Read accepted, reset_n low the next cycle -> readdatavalid stays 0; busy=0; err_count=0.
